// File: rtl/add_seq_ctrl.sv
// Slice-serial N-bit adder/subtractor: one W-bit ripple slice stepped across the operands,
// with the inter-slice carry held in a flop.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | processing slice idx, one slice per cycle
// DONE  | one-cycle done pulse; a start here begins the next operation
module add_seq_ctrl #(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int S  = N / W;
   localparam int IW = (S > 1) ? $clog2(S) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [N-1:0]  opa, opb;
   logic          carry;
   logic [IW-1:0] idx;
   logic [W-1:0]  sl_a, sl_b, sl_sum;
   logic [W:0]    rc;
   logic          take, last;

   assign take = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign last = (state == ST_RUN) && (idx == IW'(S - 1));
   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

   always_comb begin
      sl_a = '0;
      sl_b = '0;
      for (int k = 0; k < S; k++) begin
         if (idx == IW'(k)) begin
            sl_a = opa[k*W +: W];
            sl_b = opb[k*W +: W];
         end
      end
   end

   // Explicit full-adder chain so rc[W-1] (carry into the slice MSB) is available for overflow.
   always_comb begin
      rc     = '0;
      sl_sum = '0;
      rc[0]  = carry;
      for (int i = 0; i < W; i++) begin
         sl_sum[i] = sl_a[i] ^ sl_b[i] ^ rc[i];
         rc[i+1]   = (sl_a[i] & sl_b[i]) | (sl_a[i] & rc[i]) | (sl_b[i] & rc[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (take) state_nxt = ST_RUN;
         ST_RUN:  if (last) state_nxt = ST_DONE;
         ST_DONE: state_nxt = take ? ST_RUN : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa   <= '0;
         opb   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (take) begin
         opa   <= a;
         opb   <= sub ? ~b : b;
         carry <= sub;
         idx   <= '0;
      end else if (state == ST_RUN) begin
         for (int k = 0; k < S; k++) begin
            if (idx == IW'(k)) sum[k*W +: W] <= sl_sum;
         end
         carry <= rc[W];
         idx   <= idx + IW'(1);
         if (last) begin
            cout <= rc[W];
            ovf  <= rc[W-1] ^ rc[W];
         end
      end
   end

endmodule
